// File: rtl/led_cmd_decoder.sv
// Byte-stream decoder for 4-byte LED brightness frames (SYNC, ADDR, VAL, CHK).
// Holds one PWM compare value per LED channel and returns ACK/NAK for each frame.
module led_cmd_decoder #(
  parameter int unsigned CTR_LEN = 8,
  parameter int unsigned TIMEOUT = 500000,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [7:0]  ACK     = 8'h06,
  parameter logic [7:0]  NAK     = 8'h15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_new_data,
  output logic [7:0]             tx_data,
  output logic                   tx_new_data,
  input  logic                   tx_block,
  output logic [8*CTR_LEN-1:0]   compare,
  output logic                   frame_ok
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_VAL,
    GET_CHK,
    RESPOND
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, val_q;
  logic             frame_valid;
  logic             expired;

  // The CHK byte is compared live against the latched ADDR and VAL.
  assign frame_valid = (rx_data == (addr_q ^ val_q)) &&
                       ((addr_q <= 8'd7) || (addr_q == 8'hFF));
  assign expired     = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Strobe is gated combinationally by tx_block so it is never raised in a blocked cycle.
  assign tx_new_data = (state_q == RESPOND) && !tx_block;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (rx_new_data && (rx_data == SYNC)) state_d = GET_ADDR;
      end
      GET_ADDR, GET_VAL, GET_CHK: begin
        if (rx_new_data) begin
          unique case (state_q)
            GET_ADDR: state_d = GET_VAL;
            GET_VAL:  state_d = GET_CHK;
            default:  state_d = RESPOND;
          endcase
        end else if (expired) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESPOND: begin
        if (!tx_block) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: every register here, compare included, is cleared by reset so the LEDs start dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      val_q    <= '0;
      tx_data  <= '0;
      frame_ok <= 1'b0;
      compare  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frame_ok <= 1'b0;
      if (rx_new_data) begin
        unique case (state_q)
          GET_ADDR: addr_q <= rx_data;
          GET_VAL:  val_q  <= rx_data;
          GET_CHK: begin
            if (frame_valid) begin
              frame_ok <= 1'b1;
              tx_data  <= ACK;
              for (int i = 0; i < 8; i++) begin
                if ((addr_q == 8'hFF) || (addr_q == 8'(i)))
                  compare[i*CTR_LEN +: CTR_LEN] <= val_q[7 -: CTR_LEN];
              end
            end else begin
              tx_data <= NAK;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_cmd_decoder.sv
// Randomized self-checking bench for led_cmd_decoder; two instances (8-bit and 3-bit
// compare) share one byte stream and are checked every cycle against a frame-level model.
module tb_led_cmd_decoder;

  localparam int unsigned TO   = 16;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [7:0]  ACK  = 8'h06;
  localparam logic [7:0]  NAK  = 8'h15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_new_data = 1'b0;
  logic        tx_block = 1'b0;

  logic [7:0]  tx_data8, tx_data3;
  logic        tx_new_data8, tx_new_data3;
  logic [63:0] compare8;
  logic [23:0] compare3;
  logic        frame_ok8, frame_ok3;

  int checks   = 0;
  int failures = 0;

  led_cmd_decoder #(.CTR_LEN(8), .TIMEOUT(TO)) dut8 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_new_data(rx_new_data),
    .tx_data(tx_data8), .tx_new_data(tx_new_data8), .tx_block(tx_block),
    .compare(compare8), .frame_ok(frame_ok8)
  );

  led_cmd_decoder #(.CTR_LEN(3), .TIMEOUT(TO)) dut3 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_new_data(rx_new_data),
    .tx_data(tx_data3), .tx_new_data(tx_new_data3), .tx_block(tx_block),
    .compare(compare3), .frame_ok(frame_ok3)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the frame collected so far, idle cycles since the last
  // byte, the full 8-bit value last written to each channel, and any owed reply.
  logic [7:0] partial[$];
  int         quiet;
  logic [7:0] m_val [8];
  bit         reply_pending;
  logic [7:0] reply_byte;
  bit         fok_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_cmp8();
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = m_val[i];
    return r;
  endfunction

  function automatic logic [63:0] exp_cmp3();
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*3 +: 3] = 3'(m_val[i] >> 5);
    return r;
  endfunction

  task automatic model_reset();
    partial.delete();
    quiet         = 0;
    reply_pending = 0;
    reply_byte    = 8'h00;
    fok_exp       = 0;
    for (int i = 0; i < 8; i++) m_val[i] = 8'h00;
  endtask

  task automatic model_clock(input bit nd, input logic [7:0] d, input bit blk);
    logic [7:0] a, v;
    bit ok;
    fok_exp = 0;
    if (reply_pending) begin
      if (!blk) reply_pending = 0;
    end else if (nd) begin
      quiet = 0;
      if (partial.size() == 0) begin
        if (d == SYNC) partial.push_back(d);
      end else if (partial.size() < 3) begin
        partial.push_back(d);
      end else begin
        a  = partial[1];
        v  = partial[2];
        ok = (d == (a ^ v)) && ((a < 8) || (a == 8'hFF));
        if (ok) begin
          for (int ch = 0; ch < 8; ch++)
            if ((a == 8'hFF) || (a == 8'(ch))) m_val[ch] = v;
          fok_exp = 1;
        end
        reply_byte    = ok ? ACK : NAK;
        reply_pending = 1;
        partial.delete();
      end
    end else if (partial.size() != 0) begin
      quiet++;
      if (quiet == TO) begin
        partial.delete();
        quiet = 0;
      end
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit nd, input logic [7:0] d, input bit blk);
    rx_new_data = nd;
    rx_data     = nd ? d : 8'($urandom_range(0, 255));
    tx_block    = blk;
    #1;
    check("tx_new_data8", 64'(tx_new_data8), 64'(reply_pending && !blk));
    check("tx_new_data3", 64'(tx_new_data3), 64'(reply_pending && !blk));
    if (reply_pending) begin
      check("tx_data8", 64'(tx_data8), 64'(reply_byte));
      check("tx_data3", 64'(tx_data3), 64'(reply_byte));
    end
    @(posedge clk);
    model_clock(nd, d, blk);
    @(negedge clk);
    check("compare8", compare8, exp_cmp8());
    check("compare3", 64'(compare3), exp_cmp3());
    check("frame_ok8", 64'(frame_ok8), 64'(fok_exp));
    check("frame_ok3", 64'(frame_ok3), 64'(fok_exp));
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n, input bit blk);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, blk);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] v, input logic [7:0] c);
    send(SYNC); send(a); send(v); send(c);
  endtask

  // Asynchronous reset applied mid-cycle; outputs are checked while it is held.
  task automatic do_reset();
    rx_new_data = 1'b0;
    tx_block    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_compare8", compare8, 64'h0);
    check("rst_compare3", 64'(compare3), 64'h0);
    check("rst_tx_data", 64'(tx_data8), 64'h0);
    check("rst_tx_new_data", 64'(tx_new_data8 | tx_new_data3), 64'h0);
    check("rst_frame_ok", 64'(frame_ok8 | frame_ok3), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single channel, broadcast, bad checksum, bad address.
    frame(8'h03, 8'h80, 8'h83); idle(3, 1'b0);
    frame(8'hFF, 8'h40, 8'hBF); idle(3, 1'b0);
    frame(8'h03, 8'h40, 8'h00); idle(3, 1'b0);
    frame(8'h09, 8'h10, 8'h19); idle(3, 1'b0);

    // Abandoned partial frame, then a good one.
    send(SYNC); send(8'h02); idle(TO, 1'b0);
    frame(8'h02, 8'hFF, 8'hFD); idle(3, 1'b0);

    // Byte arriving in the expiry cycle is still accepted.
    send(SYNC); idle(TO - 1, 1'b0);
    send(8'h07); send(8'h11); send(8'h16); idle(3, 1'b0);

    // Reply held back by tx_block with a stray byte injected.
    frame(8'h04, 8'h20, 8'h24);
    idle(50, 1'b1); step(1'b1, 8'h55, 1'b1); idle(49, 1'b1); idle(3, 1'b0);

    // Truncation to 3-bit compare values.
    frame(8'h05, 8'hE0, 8'hE5); idle(3, 1'b0);
    frame(8'h05, 8'h3F, 8'h3A); idle(3, 1'b0);

    // Reset mid-frame, then reset while a reply is owed.
    frame(8'h01, 8'hFF, 8'hFE); idle(3, 1'b0);
    send(SYNC); send(8'h01); do_reset(); idle(3, 1'b0);
    frame(8'h06, 8'h77, 8'h71); idle(3, 1'b0);
    frame(8'h00, 8'h12, 8'h12); idle(5, 1'b1); do_reset(); idle(3, 1'b0);

    // Random traffic: mostly well-formed frames with gaps, junk, blocking and timeouts.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] bytes [4];
      int r;
      r        = $urandom_range(0, 99);
      bytes[0] = (r < 90) ? SYNC : 8'($urandom_range(0, 255));
      r        = $urandom_range(0, 99);
      bytes[1] = (r < 60) ? 8'($urandom_range(0, 7)) : (r < 85) ? 8'hFF : 8'($urandom_range(0, 255));
      bytes[2] = 8'($urandom_range(0, 255));
      bytes[3] = ($urandom_range(0, 99) < 80) ? (bytes[1] ^ bytes[2]) : 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) begin
        step(1'b1, bytes[k], $urandom_range(0, 99) < 20);
        r = $urandom_range(0, 99);
        if (r < 5) idle(TO - 1 + $urandom_range(0, 2), 1'b0);
        else       idle($urandom_range(0, 2), $urandom_range(0, 99) < 30);
      end
      idle($urandom_range(0, 3), $urandom_range(0, 99) < 40);
    end
    idle(4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
